// File: rtl/sram_rw_arbiter_if.sv
// Bundle of requester handshakes and SRAM RW0 port signals around sram_rw_arbiter.
`default_nettype none

interface sram_rw_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 128,
  parameter int MASK_W = 4
);
  logic              r0_req_valid;
  logic              r0_req_ready;
  logic              r0_req_write;
  logic [ADDR_W-1:0] r0_req_addr;
  logic [MASK_W-1:0] r0_req_wmask;
  logic [DATA_W-1:0] r0_req_wdata;
  logic              r0_resp_valid;
  logic [DATA_W-1:0] r0_resp_rdata;

  logic              r1_req_valid;
  logic              r1_req_ready;
  logic              r1_req_write;
  logic [ADDR_W-1:0] r1_req_addr;
  logic [MASK_W-1:0] r1_req_wmask;
  logic [DATA_W-1:0] r1_req_wdata;
  logic              r1_resp_valid;
  logic [DATA_W-1:0] r1_resp_rdata;

  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  logic              init_done;

  modport slave (
    input  r0_req_valid, r0_req_write, r0_req_addr, r0_req_wmask, r0_req_wdata,
    output r0_req_ready, r0_resp_valid, r0_resp_rdata,
    input  r1_req_valid, r1_req_write, r1_req_addr, r1_req_wmask, r1_req_wdata,
    output r1_req_ready, r1_resp_valid, r1_resp_rdata,
    output sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
    input  sram_rdata,
    output init_done
  );

  modport master (
    output r0_req_valid, r0_req_write, r0_req_addr, r0_req_wmask, r0_req_wdata,
    input  r0_req_ready, r0_resp_valid, r0_resp_rdata,
    output r1_req_valid, r1_req_write, r1_req_addr, r1_req_wmask, r1_req_wdata,
    input  r1_req_ready, r1_resp_valid, r1_resp_rdata,
    input  sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
    output sram_rdata,
    input  init_done
  );
endinterface

`default_nettype wire

// File: rtl/sram_rw_arbiter.sv
// Round-robin arbiter sharing one RW0-style SRAM between two requesters.
// Optional post-reset zero sweep enabled by defining SRAM_ARB_INIT_EN.
`default_nettype none

module sram_rw_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 128,
  parameter int MASK_W = 4
) (
  input  wire logic         clock,
  input  wire logic         reset_n,
  sram_rw_arbiter_if.slave  bus
);

  logic w_open;
  logic w_gnt0;
  logic w_gnt1;
  logic prio_q, prio_d;
  logic rsp_pend_q, rsp_pend_d;
  logic rsp_id_q, rsp_id_d;

`ifdef SRAM_ARB_INIT_EN
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
  logic              w_sweep;

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT) begin
      // Counter parks at the last address instead of wrapping.
      if (init_addr_q == {ADDR_W{1'b1}}) state_d = ST_RUN;
      else                               init_addr_d = init_addr_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  assign w_sweep       = reset_n && (state_q == ST_INIT);
  assign w_open        = reset_n && (state_q == ST_RUN);
  assign bus.init_done = (state_q == ST_RUN);
`else
  assign w_open        = reset_n;
  assign bus.init_done = 1'b1;
`endif

  // prio_q names the requester that wins a tie.
  assign w_gnt0 = w_open && bus.r0_req_valid && (!bus.r1_req_valid || !prio_q);
  assign w_gnt1 = w_open && bus.r1_req_valid && (!bus.r0_req_valid ||  prio_q);

  assign bus.r0_req_ready = w_gnt0;
  assign bus.r1_req_ready = w_gnt1;

  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_wmode = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wmask = '0;
    bus.sram_wdata = '0;
`ifdef SRAM_ARB_INIT_EN
    if (w_sweep) begin
      bus.sram_en    = 1'b1;
      bus.sram_wmode = 1'b1;
      bus.sram_addr  = init_addr_q;
      bus.sram_wmask = {MASK_W{1'b1}};
    end else
`endif
    if (w_gnt0) begin
      bus.sram_en    = 1'b1;
      bus.sram_wmode = bus.r0_req_write;
      bus.sram_addr  = bus.r0_req_addr;
      bus.sram_wmask = bus.r0_req_wmask;
      bus.sram_wdata = bus.r0_req_wdata;
    end else if (w_gnt1) begin
      bus.sram_en    = 1'b1;
      bus.sram_wmode = bus.r1_req_write;
      bus.sram_addr  = bus.r1_req_addr;
      bus.sram_wmask = bus.r1_req_wmask;
      bus.sram_wdata = bus.r1_req_wdata;
    end
  end

  always_comb begin
    prio_d     = prio_q;
    if (w_gnt0)      prio_d = 1'b1;
    else if (w_gnt1) prio_d = 1'b0;
    rsp_pend_d = (w_gnt0 && !bus.r0_req_write) || (w_gnt1 && !bus.r1_req_write);
    rsp_id_d   = w_gnt1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_q     <= 1'b0;
      rsp_pend_q <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      rsp_pend_q <= rsp_pend_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign bus.r0_resp_valid = rsp_pend_q && !rsp_id_q;
  assign bus.r1_resp_valid = rsp_pend_q &&  rsp_id_q;
  assign bus.r0_resp_rdata = bus.sram_rdata;
  assign bus.r1_resp_rdata = bus.sram_rdata;

endmodule

`default_nettype wire

// File: tb/tb_sram_rw_arbiter.sv
// Directed self-checking bench for sram_rw_arbiter with a behavioural RW0 SRAM.
`default_nettype none

module tb_sram_rw_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 128;
  localparam int MASK_W = 4;
  localparam int DEPTH  = 2**ADDR_W;
  localparam int LANE   = DATA_W / MASK_W;

  localparam logic [DATA_W-1:0] D_A5  = {16{8'hA5}};
  localparam logic [DATA_W-1:0] D_10  = {4{32'h1010_1010}};
  localparam logic [DATA_W-1:0] D_20  = {4{32'h2020_2020}};
  localparam logic [DATA_W-1:0] D_MSK = {32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};

  logic clock = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  sram_rw_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

  sram_rw_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_q = '0;

  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

  always @(posedge clock) begin
    if (bus.sram_en) begin
      if (bus.sram_wmode) begin
        for (int l = 0; l < MASK_W; l++)
          if (bus.sram_wmask[l]) mem[bus.sram_addr][l*LANE +: LANE] <= bus.sram_wdata[l*LANE +: LANE];
      end else begin
        rdata_q <= mem[bus.sram_addr];
      end
    end
  end
  assign bus.sram_rdata = rdata_q;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.r0_req_valid = 1'b0; bus.r0_req_write = 1'b0; bus.r0_req_addr = '0;
    bus.r0_req_wmask = '0;   bus.r0_req_wdata = '0;
    bus.r1_req_valid = 1'b0; bus.r1_req_write = 1'b0; bus.r1_req_addr = '0;
    bus.r1_req_wmask = '0;   bus.r1_req_wdata = '0;
  endtask

  task automatic req(input int n, input logic w, input logic [ADDR_W-1:0] a,
                     input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
    if (n == 0) begin
      bus.r0_req_valid = 1'b1; bus.r0_req_write = w; bus.r0_req_addr = a;
      bus.r0_req_wmask = m;    bus.r0_req_wdata = d;
    end else begin
      bus.r1_req_valid = 1'b1; bus.r1_req_write = w; bus.r1_req_addr = a;
      bus.r1_req_wmask = m;    bus.r1_req_wdata = d;
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wait_init(input bit check_len);
    int edges = 0;
    bit ready_seen = 1'b0;
    while (bus.init_done !== 1'b1 && edges < DEPTH + 4) begin
      @(negedge clock);
      if (bus.r0_req_ready !== 1'b0 || bus.r1_req_ready !== 1'b0 || bus.sram_en !== 1'b1)
        ready_seen = 1'b1;
      tick();
      edges++;
    end
    if (check_len) chk("init_cycles", edges, DEPTH);
    chk("init_sweep_outputs", ready_seen, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    idle();
    req(0, 1'b0, 10'h005, '0, '0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ready0", bus.r0_req_ready, 1'b0);
    chk("rst_sram_en", bus.sram_en, 1'b0);
    chk("rst_sram_addr", bus.sram_addr, '0);
    chk("rst_resp0", bus.r0_resp_valid, 1'b0);
`ifdef SRAM_ARB_INIT_EN
    chk("rst_init_done", bus.init_done, 1'b0);
`else
    chk("rst_init_done", bus.init_done, 1'b1);
`endif
    tick();
    reset_n = 1'b1;
    idle();
`ifdef SRAM_ARB_INIT_EN
    wait_init(1'b1);
`endif

    // Preload through the arbiter; prio ends at 1 after the last r0 grant.
    req(0, 1'b1, 10'h005, 4'hF, D_A5);
    @(negedge clock);
    chk("wr5_ready0", bus.r0_req_ready, 1'b1);
    chk("wr5_wmode", bus.sram_wmode, 1'b1);
    chk("wr5_addr", bus.sram_addr, 10'h005);
    tick(); idle();
    req(1, 1'b1, 10'h010, 4'hF, D_10);
    @(negedge clock);
    chk("wr10_ready1", bus.r1_req_ready, 1'b1);
    tick(); idle();
    req(0, 1'b1, 10'h020, 4'hF, D_20);
    tick(); idle();

    req(0, 1'b0, 10'h005, '0, '0);
    @(negedge clock);
    chk("rd5_ready0", bus.r0_req_ready, 1'b1);
    chk("rd5_wmode", bus.sram_wmode, 1'b0);
    tick(); idle();
    @(negedge clock);
    chk("rd5_resp0", bus.r0_resp_valid, 1'b1);
    chk("rd5_resp1", bus.r1_resp_valid, 1'b0);
    chk("rd5_data", bus.r0_resp_rdata, D_A5);
    chk("idle_sram_en", bus.sram_en, 1'b0);

    tick();
    req(1, 1'b1, 10'h003, 4'b0101, {DATA_W{1'b1}});
    @(negedge clock);
    chk("mwr_ready1", bus.r1_req_ready, 1'b1);
    chk("mwr_mask", bus.sram_wmask, 4'b0101);
    tick(); idle();

    // prio is now 0: contention must alternate r0,r1,...
    req(0, 1'b0, 10'h010, '0, '0);
    req(1, 1'b0, 10'h020, '0, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("cont_ready0", bus.r0_req_ready, (i % 2) == 0);
      chk("cont_ready1", bus.r1_req_ready, (i % 2) == 1);
      if (i > 0) begin
        chk("cont_resp0", bus.r0_resp_valid, (i % 2) == 1);
        chk("cont_resp1", bus.r1_resp_valid, (i % 2) == 0);
        chk("cont_data", bus.r0_resp_rdata, ((i % 2) == 1) ? D_10 : D_20);
      end
      tick();
    end
    idle();
    @(negedge clock);
    chk("cont_last_resp1", bus.r1_resp_valid, 1'b1);
    chk("cont_last_data", bus.r1_resp_rdata, D_20);
    tick();

    req(0, 1'b0, 10'h003, '0, '0);
    tick(); idle();
    @(negedge clock);
    chk("mrd_resp0", bus.r0_resp_valid, 1'b1);
    chk("mrd_data", bus.r0_resp_rdata, D_MSK);
    tick();

    req(1, 1'b1, 10'h005, 4'h0, '0);
    @(negedge clock);
    chk("zmask_ready1", bus.r1_req_ready, 1'b1);
    tick(); idle();
    req(0, 1'b0, 10'h005, '0, '0);
    tick(); idle();
    @(negedge clock);
    chk("zmask_data", bus.r0_resp_rdata, D_A5);
    tick();

    req(1, 1'b1, 10'h3FF, 4'hF, 128'h1234);
    tick(); idle();
    req(0, 1'b0, 10'h3FF, '0, '0);
    @(negedge clock);
    chk("wtr_ready0", bus.r0_req_ready, 1'b1);
    tick(); idle();
    @(negedge clock);
    chk("wtr_resp0", bus.r0_resp_valid, 1'b1);
    chk("wtr_data", bus.r0_resp_rdata, 128'h1234);
    tick();

    // Read accepted, then reset before its response; prio was left at 1.
    req(0, 1'b0, 10'h010, '0, '0);
    tick();
    reset_n = 1'b0;
    idle();
    @(negedge clock);
    chk("mrst_resp0", bus.r0_resp_valid, 1'b0);
    chk("mrst_sram_en", bus.sram_en, 1'b0);
    tick();
    reset_n = 1'b1;
`ifdef SRAM_ARB_INIT_EN
    wait_init(1'b0);
`endif
    req(0, 1'b0, 10'h020, '0, '0);
    req(1, 1'b0, 10'h010, '0, '0);
    @(negedge clock);
    chk("post_rst_ready0", bus.r0_req_ready, 1'b1);
    chk("post_rst_ready1", bus.r1_req_ready, 1'b0);
    chk("post_rst_addr", bus.sram_addr, 10'h020);
    tick(); idle();
    @(negedge clock);
    chk("post_rst_resp0", bus.r0_resp_valid, 1'b1);
    chk("post_rst_data", bus.r0_resp_rdata, D_20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
